cb_sink: RTL and testbench

CB_SINK -- requirements
Module: cb_sink

---
 rtl/cb_pkg.sv | 12 +
 rtl/cb_sink_fifo.sv | 59 +++++
 rtl/cb_sink.sv | 58 +++++
 tb/tb_cb_sink.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
// Shared crossbar definitions: default payload width and the word entry type.
package cb_pkg;

  localparam int CB_WIDTH = 8;

  // One crossbar word as it travels through cb and into the sinks
  typedef struct packed {
    logic                src;
    logic [CB_WIDTH-1:0] data;
  } cb_entry_t;

endpackage

// File: rtl/cb_sink_fifo.sv
// First-word-fall-through FIFO holding {src,data} words for cb_sink.
// Storage is not reset; pointers and occupancy are.
module cb_sink_fifo
  import cb_pkg::*;
#(
  parameter int WIDTH = CB_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_val,
  input  logic [WIDTH:0]           push_entry,
  output logic                     push_rdy,
  output logic                     pop_val,
  output logic [WIDTH:0]           pop_entry,
  input  logic                     pop_rdy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH:0] mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic           push, pop;

  // Ready/valid derive from registered occupancy only, so a pop cannot
  // open a slot for a push in the same cycle.
  always_comb begin
    push_rdy = (level != FULL_LVL);
    pop_val  = (level != '0);
    push     = push_val && push_rdy;
    pop      = pop_val && pop_rdy;
    pop_entry = mem[rptr];
  end

  // Word storage; contents are only observed while occupancy covers them
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_entry;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/cb_sink.sv
// Crossbar master-port sink: buffers words in a FWFT FIFO and keeps
// saturating per-source accept counters.
module cb_sink
  import cb_pkg::*;
#(
  parameter int WIDTH = CB_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_val,
  input  logic                   in_src,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_rdy,
  output logic                   out_val,
  output logic                   out_src,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_rdy,
  output logic [CNT_W-1:0]       cnt0,
  output logic [CNT_W-1:0]       cnt1,
  output logic [$clog2(DEPTH):0] level
);

  logic [WIDTH:0] head;
  logic           accept;

  cb_sink_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_val   (in_val),
    .push_entry ({in_src, in_data}),
    .push_rdy   (in_rdy),
    .pop_val    (out_val),
    .pop_entry  (head),
    .pop_rdy    (out_rdy),
    .level      (level)
  );

  // Split the head entry and qualify the accept strobe for the counters
  always_comb begin
    out_src  = head[WIDTH];
    out_data = head[WIDTH-1:0];
    accept   = in_val && in_rdy;
  end

  // Per-source accept counters, holding at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (accept) begin
      if (!in_src && cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
      if ( in_src && cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cb_sink.sv
// Randomized + directed bench for cb_sink against a queue-based model.
module tb_cb_sink;
  import cb_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 0;
  logic       rst = 1;
  logic       in_val = 0, in_src = 0, out_rdy = 0;
  logic [7:0] in_data = '0;
  logic       in_rdy, out_val, out_src;
  logic [7:0] out_data;
  logic [7:0] cnt0, cnt1;
  logic [2:0] level;
  // Narrow-counter copy sharing the same stimulus
  logic       in_rdy2, out_val2, out_src2;
  logic [7:0] out_data2;
  logic [1:0] cnt0_2, cnt1_2;
  logic [2:0] level2;

  cb_sink #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_src(in_src), .in_data(in_data),
    .in_rdy(in_rdy), .out_val(out_val), .out_src(out_src), .out_data(out_data),
    .out_rdy(out_rdy), .cnt0(cnt0), .cnt1(cnt1), .level(level));

  cb_sink #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_src(in_src), .in_data(in_data),
    .in_rdy(in_rdy2), .out_val(out_val2), .out_src(out_src2), .out_data(out_data2),
    .out_rdy(out_rdy), .cnt0(cnt0_2), .cnt1(cnt1_2), .level(level2));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  cb_entry_t q[$];
  int n0 = 0, n1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int m = (1 << w) - 1;
    return (n > m) ? m : n;
  endfunction

  // Compare all observable outputs against the model (called mid-cycle)
  task automatic check_state(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".in_rdy"}, 32'(in_rdy), 32'(q.size() < DEPTH));
    chk({tag, ".out_val"}, 32'(out_val), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, ".out_data"}, 32'(out_data), 32'(q[0].data));
      chk({tag, ".out_src"}, 32'(out_src), 32'(q[0].src));
    end
    chk({tag, ".cnt0"}, 32'(cnt0), 32'(sat(n0, 8)));
    chk({tag, ".cnt1"}, 32'(cnt1), 32'(sat(n1, 8)));
    chk({tag, ".cnt0_w2"}, 32'(cnt0_2), 32'(sat(n0, 2)));
    chk({tag, ".cnt1_w2"}, 32'(cnt1_2), 32'(sat(n1, 2)));
    chk({tag, ".level_w2"}, 32'(level2), 32'(q.size()));
  endtask

  // One clock: drive inputs, check pre-edge state, advance model at the edge
  task automatic step(input string tag, input logic v, input logic s,
                      input logic [7:0] d, input logic r);
    bit do_push, do_pop;
    cb_entry_t e;
    in_val = v; in_src = s; in_data = d; out_rdy = r;
    #1;
    check_state(tag);
    do_push = v && (q.size() < DEPTH);
    do_pop  = r && (q.size() > 0);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.src = s; e.data = d;
      q.push_back(e);
      if (s) n1++; else n0++;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete(); n0 = 0; n1 = 0;
  endtask

  initial begin
    logic [7:0] wl [4];
    wl[0] = 8'h22; wl[1] = 8'h15; wl[2] = 8'h01; wl[3] = 8'h02;

    // Reset state
    repeat (2) @(negedge clk);
    check_state("reset");
    rst = 0;
    @(negedge clk);
    check_state("post_reset");

    // Single word into empty FIFO, visible next cycle
    step("w2b", 1, 0, 8'h2B, 1);
    chk("w2b.out_val", 32'(out_val), 32'd1);
    chk("w2b.out_data", 32'(out_data), 32'h2B);
    step("w2b_pop", 0, 0, 8'h00, 1);

    // Fill to full, extra push ignored, drain in order
    for (int i = 0; i < 4; i++) step("fill", 1, i[0], wl[i], 0);
    chk("full.level", 32'(level), 32'd4);
    chk("full.in_rdy", 32'(in_rdy), 32'd0);
    step("fifth", 1, 0, 8'h77, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain.order", 32'(out_data), 32'(wl[i]));
      step("drain", 0, 0, 8'h00, 1);
    end

    // Full with simultaneous push and pop: pop only, then push+pop
    for (int i = 0; i < 4; i++) step("fill2", 1, i[0], 8'(8'h40 + i), 0);
    step("fullpp", 1, 0, 8'h55, 1);
    chk("fullpp.level", 32'(level), 32'd3);
    chk("fullpp.in_rdy", 32'(in_rdy), 32'd1);
    step("pp", 1, 1, 8'h66, 1);
    chk("pp.level", 32'(level), 32'd3);
    repeat (4) step("drain2", 0, 0, 8'h00, 1);

    // Continuous stream with out_rdy toggling across pointer wrap
    for (int i = 0; i < 10; i++) step("stream", 1, i[1], 8'(8'hA0 + i), i[0]);
    repeat (8) step("drain3", 0, 0, 8'h00, 1);
    chk("stream.empty", 32'(out_val), 32'd0);

    // Narrow counter saturation on source 1
    for (int i = 0; i < 5; i++) step("sat", 1, 1, 8'(i), 1);
    step("sat_hold", 0, 0, 8'h00, 1);
    chk("sat.cnt1_w2", 32'(cnt1_2), 32'd3);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(9) < 7), 1'($urandom), 8'($urandom), 1'($urandom));

    // Async reset mid-cycle with three words stored
    repeat (4) step("drain4", 0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 8'(8'hC0 + i), 0);
    chk("pre_rst.level", 32'(level), 32'd3);
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst.out_val", 32'(out_val), 32'd0);
    chk("arst.level", 32'(level), 32'd0);
    @(negedge clk);
    rst = 0;
    #1;
    check_state("arst_rel");

    // Nothing stale after reset
    for (int i = 0; i < 40; i++)
      step("rand2", ($urandom_range(9) < 6), 1'($urandom), 8'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
